// File: rtl/cpu_move_picker.sv
// cpu_move_picker: picks a legal computer move from random row/column indices, falls back to a linear scan; optional stats via CPU_MOVE_STATS_EN
module cpu_move_picker #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int IDX_W     = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IDX_W-1:0]     rand_fila,
  input  logic [IDX_W-1:0]     rand_col,
  input  logic [ROWS*COLS-1:0] occupied,
  input  logic                 move_ready,
  output logic                 busy,
  output logic                 move_valid,
  output logic [IDX_W-1:0]     move_fila,
  output logic [IDX_W-1:0]     move_col,
  output logic                 move_fallback,
  output logic                 board_full
`ifdef CPU_MOVE_STATS_EN
  ,
  output logic [7:0]           last_tries,
  output logic [15:0]          fallback_count
`endif
);
  localparam int N  = ROWS * COLS;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, SCAN, OFFER} state_t;
  state_t state, state_nx;
  logic [7:0]       tries;
  logic [SW-1:0]    scan_idx;
  logic [IDX_W-1:0] cand_fila, cand_col;
  logic [SW-1:0]    cand_idx;
  logic             cand_ok, scan_free, scan_last, tries_done;
  // Out-of-range candidates are rejected before the board bit can matter.
  assign cand_idx   = SW'(cand_fila * COLS + cand_col);
  assign cand_ok    = (32'(cand_fila) < ROWS) && (32'(cand_col) < COLS) && !occupied[cand_idx];
  assign scan_free  = !occupied[scan_idx];
  assign scan_last  = 32'(scan_idx) == N - 1;
  assign tries_done = 32'(tries) + 1 == MAX_TRIES;
  assign busy       = state != IDLE;
  assign move_valid = state == OFFER;
  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SAMPLE : IDLE;
      SAMPLE:  state_nx = CHECK;
      CHECK:   state_nx = cand_ok ? OFFER : (tries_done ? SCAN : SAMPLE);
      SCAN:    state_nx = scan_free ? OFFER : (scan_last ? IDLE : SCAN);
      OFFER:   state_nx = move_ready ? IDLE : OFFER;
      default: state_nx = IDLE;
    endcase
  end
  // Candidate capture, try counting, scan walk and move registers.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tries         <= '0;
      scan_idx      <= '0;
      cand_fila     <= '0;
      cand_col      <= '0;
      move_fila     <= '0;
      move_col      <= '0;
      move_fallback <= 1'b0;
      board_full    <= 1'b0;
`ifdef CPU_MOVE_STATS_EN
      last_tries     <= '0;
      fallback_count <= '0;
`endif
    end else begin
      board_full <= state == SCAN && !scan_free && scan_last;
      if (state == IDLE && start) tries <= '0;
      if (state == SAMPLE) begin
        cand_fila <= rand_fila;
        cand_col  <= rand_col;
      end
      if (state == CHECK && cand_ok) begin
        move_fila     <= cand_fila;
        move_col      <= cand_col;
        move_fallback <= 1'b0;
`ifdef CPU_MOVE_STATS_EN
        last_tries    <= tries + 8'd1;
`endif
      end
      if (state == CHECK && !cand_ok) begin
        tries    <= tries + 8'd1;
        scan_idx <= '0;
      end
      if (state == SCAN && scan_free) begin
        move_fila     <= IDX_W'(32'(scan_idx) / COLS);
        move_col      <= IDX_W'(32'(scan_idx) % COLS);
        move_fallback <= 1'b1;
`ifdef CPU_MOVE_STATS_EN
        last_tries    <= 8'(MAX_TRIES);
        if (fallback_count != 16'hFFFF) fallback_count <= fallback_count + 16'd1;
`endif
      end
      if (state == SCAN && !scan_free) scan_idx <= scan_idx + SW'(1);
    end
endmodule

// File: tb/tb_cpu_move_picker.sv
// tb_cpu_move_picker: randomized self-checking bench for cpu_move_picker against a behavioural move model
module tb_cpu_move_picker;
  localparam int ROWS = 5, COLS = 5, IDX_W = 4, MT = 8, N = 25;
  logic clk = 1'b0;
  logic reset, start, move_ready;
  logic [IDX_W-1:0] rand_fila, rand_col;
  logic [N-1:0] occupied;
  logic busy, move_valid, move_fallback, board_full;
  logic [IDX_W-1:0] move_fila, move_col;
`ifdef CPU_MOVE_STATS_EN
  logic [7:0]  last_tries;
  logic [15:0] fallback_count;
`endif
  int checks = 0, failures = 0;
  int pf[MT], pc[MT];
  int fb_model = 0;

  cpu_move_picker #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .start(start), .rand_fila(rand_fila), .rand_col(rand_col),
    .occupied(occupied), .move_ready(move_ready), .busy(busy), .move_valid(move_valid),
    .move_fila(move_fila), .move_col(move_col), .move_fallback(move_fallback), .board_full(board_full)
`ifdef CPU_MOVE_STATS_EN
    , .last_tries(last_tries), .fallback_count(fallback_count)
`endif
  );

  always #5 clk = ~clk;

  // Request one move; the model decides hit / fallback / full from the attempt list and the board.
  task automatic run_move(input logic [N-1:0] occ, input int hold, input bit poke_start, input string tag);
    int kind, er, ec, et, lat, cnt, f;
    logic [8:0] ev;
    kind = -1; er = 0; ec = 0; et = 0; lat = 0; f = -1;
    for (int i = 0; i < MT && kind < 0; i++)
      if (pf[i] < ROWS && pc[i] < COLS && !occ[pf[i]*COLS+pc[i]]) begin
        kind = 0; er = pf[i]; ec = pc[i]; et = i + 1; lat = 3 + 2*i;
      end
    if (kind < 0) begin
      for (int i = N - 1; i >= 0; i--) if (!occ[i]) f = i;
      kind = (f < 0) ? 2 : 1;
      et = MT;
      lat = (f < 0) ? 1 + 2*MT + N : 2 + 2*MT + f;
      if (f >= 0) begin er = f / COLS; ec = f % COLS; fb_model++; end
    end
    ev = {4'(er), 4'(ec), kind == 1};
    occupied = occ; move_ready = 1'b0;
    rand_fila = 4'(pf[0]); rand_col = 4'(pc[0]); start = 1'b1;
    @(posedge clk); #1 start = 1'b0; cnt = 1;
    while (!move_valid && !board_full && cnt < 300) begin
      @(posedge clk); cnt++; #1;
      if (cnt % 2 == 1 && (cnt - 1) / 2 < MT) begin
        rand_fila = 4'(pf[(cnt-1)/2]); rand_col = 4'(pc[(cnt-1)/2]);
      end
    end
    checks++;
    if (cnt != lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", tag, cnt, lat); end
    if (kind == 2) begin
      checks++;
      if (board_full !== 1'b1 || move_valid !== 1'b0) begin
        failures++; $display("FAIL %s full_pulse got full=%b valid=%b exp full=1 valid=0", tag, board_full, move_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (board_full !== 1'b0 || busy !== 1'b0 || move_valid !== 1'b0) begin
        failures++; $display("FAIL %s full_end got full=%b busy=%b valid=%b exp 0 0 0", tag, board_full, busy, move_valid);
      end
    end else begin
      checks++;
      if ({move_fila, move_col, move_fallback} !== ev) begin
        failures++; $display("FAIL %s move got=(%0d,%0d,fb%b) exp=(%0d,%0d,fb%b)", tag, move_fila, move_col, move_fallback, er, ec, ev[0]);
      end
`ifdef CPU_MOVE_STATS_EN
      checks++;
      if (last_tries !== 8'(et) || fallback_count !== 16'(fb_model)) begin
        failures++; $display("FAIL %s stats got tries=%0d fbc=%0d exp tries=%0d fbc=%0d", tag, last_tries, fallback_count, et, fb_model);
      end
`endif
      for (int k = 0; k < hold; k++) begin
        if (poke_start && k == 2) start = 1'b1;
        rand_fila = 4'($urandom); rand_col = 4'($urandom);
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (move_valid !== 1'b1 || {move_fila, move_col, move_fallback} !== ev) begin
          failures++; $display("FAIL %s stall%0d got valid=%b (%0d,%0d,fb%b) exp valid=1 (%0d,%0d,fb%b)", tag, k, move_valid, move_fila, move_col, move_fallback, er, ec, ev[0]);
        end
      end
      move_ready = 1'b1;
      @(posedge clk); #1 move_ready = 1'b0;
      checks++;
      if (move_valid !== 1'b0 || busy !== 1'b0 || {move_fila, move_col} !== ev[8:1]) begin
        failures++; $display("FAIL %s accept got valid=%b busy=%b (%0d,%0d) exp valid=0 busy=0 (%0d,%0d)", tag, move_valid, busy, move_fila, move_col, er, ec);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_pairs(input int f, input int c);
    for (int i = 0; i < MT; i++) begin pf[i] = f; pc[i] = c; end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; move_ready = 1'b0; rand_fila = '0; rand_col = '0; occupied = '0;
    #12;
    checks++;
    if ({busy, move_valid, move_fila, move_col, move_fallback, board_full} !== '0) begin
      failures++; $display("FAIL reset outputs got=%b exp=0", {busy, move_valid, move_fila, move_col, move_fallback, board_full});
    end
`ifdef CPU_MOVE_STATS_EN
    checks++;
    if (last_tries !== 8'd0 || fallback_count !== 16'd0) begin
      failures++; $display("FAIL reset stats got tries=%0d fbc=%0d exp 0 0", last_tries, fallback_count);
    end
`endif
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_first_try();
    set_pairs(2, 3);
    run_move('0, 0, 1'b0, "first_try");
  endtask

  task automatic test_retry();
    set_pairs(0, 1); pf[0] = 2; pc[0] = 3; pf[1] = 2; pc[1] = 3;
    run_move(25'd1 << 13, 0, 1'b0, "retry");
  endtask

  task automatic test_fallback();
    set_pairs(7, 0);
    run_move(~(25'd1 << 24), 0, 1'b0, "fallback");
  endtask

  task automatic test_board_full();
    set_pairs(1, 1);
    run_move('1, 0, 1'b0, "board_full");
  endtask

  task automatic test_stall();
    set_pairs(4, 0);
    run_move(25'h00F0F0F, 10, 1'b1, "stall");
  endtask

  task automatic test_random();
    logic [N-1:0] occ;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < MT; i++) begin pf[i] = $urandom_range(0, 7); pc[i] = $urandom_range(0, 7); end
      occ = N'($urandom | $urandom);
      if (t % 8 == 7) occ = '1;
      run_move(occ, $urandom_range(0, 3), 1'b0, "random");
    end
  endtask

  task automatic test_async_reset();
    set_pairs(7, 7);
    occupied = '1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 22; i++) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL async_pre busy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, move_valid, move_fila, move_col, move_fallback, board_full} !== '0) begin
      failures++; $display("FAIL async_reset outputs got=%b exp=0", {busy, move_valid, move_fila, move_col, move_fallback, board_full});
    end
    fb_model = 0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    set_pairs(2, 3);
    run_move('0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_first_try();
    test_retry();
    test_fallback();
    test_board_full();
    test_stall();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_move_picker.md
Name: cpu_move_picker

Overview:
- Consumes the random row index from the random row selector, plus a random column index from a second selector.
- Turns them into a legal computer move on a ROWS x COLS board.
- Rejects occupied or out-of-range cells and retries up to MAX_TRIES times. After that it falls back to a deterministic linear scan.
- Delivers the move to the game controller over a valid/ready handshake.

Parameters:
- ROWS, 5, board rows; legal row indices 0..ROWS-1.
- COLS, 5, board columns; legal column indices 0..COLS-1.
- IDX_W, 4, width of the row and column index buses.
- MAX_TRIES, 8, random attempts before the linear-scan fallback (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one move; sampled only in IDLE.
- rand_fila  in  IDX_W  random row from the row selector.
- rand_col  in  IDX_W  random column from the column selector.
- occupied  in  ROWS*COLS  1 = cell taken; bit index r*COLS+c.
- move_ready  in  1  consumer accepts the move.
- busy  out  1  high in every state except IDLE.
- move_valid  out  1  move offered.
- move_fila  out  IDX_W  chosen row.
- move_col  out  IDX_W  chosen column.
- move_fallback  out  1  move came from the linear scan.
- board_full  out  1  one-cycle pulse: no free cell exists.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE; tries=0; scan index=0.
  - All outputs 0.
- States: IDLE, SAMPLE, CHECK, SCAN, OFFER.
- IDLE:
  - start=1 moves to SAMPLE and clears tries.
  - start is ignored in all other states; there is no queueing.
- SAMPLE (1 cycle):
  - Registers rand_fila and rand_col into the candidate registers.
  - Goes to CHECK.
- CHECK (1 cycle):
  - Candidate is legal when fila<ROWS, col<COLS and occupied[fila*COLS+col]=0.
  - Legal: load move_fila/move_col, move_fallback=0, go to OFFER.
  - Illegal: tries=tries+1. If the new tries==MAX_TRIES, go to SCAN with scan index=0; otherwise go to SAMPLE.
  - Out-of-range indices count as a failed try.
- SCAN (one cell per cycle, index 0..ROWS*COLS-1 ascending):
  - First free cell: move_fila=idx/COLS, move_col=idx%COLS, move_fallback=1, go to OFFER.
  - Last index occupied: board_full=1 for exactly one cycle, return to IDLE, no move offered.
- OFFER:
  - move_valid=1. move_fila, move_col and move_fallback are held stable until the handshake.
  - Handshake is move_valid & move_ready on a rising edge. In that cycle: move_valid drops to 0 on the next edge, return to IDLE.
  - move_ready while not in OFFER has no effect.
  - move_fila/move_col keep their last value after acceptance.
- Latency, start edge to move_valid:
  - First-try hit: 3 cycles (SAMPLE, CHECK, OFFER).
  - Each miss adds 2 cycles.
  - Fallback adds MAX_TRIES*2 + (idx+1) cycles.
- occupied must be stable while busy=1. The block samples it combinationally in CHECK and SCAN.
- busy=0 in the cycle after handshake acceptance or after the board_full pulse.
- Widths:
  - tries counter is 8 bits.
  - Scan index width is $clog2(ROWS*COLS).
  - Row index computation truncates to IDX_W.

Optional Feature:
- Macro: CPU_MOVE_STATS_EN.
- Defined:
  - Adds output last_tries [7:0]. On each entry to OFFER it captures the number of random attempts used (1..MAX_TRIES, or MAX_TRIES for a fallback move).
  - Adds output fallback_count [15:0], which increments on every fallback move and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port nor register exists; all other behaviour is identical.

Test Plan:
- Empty board, rand_fila=2, rand_col=3, start pulse, move_ready=1: move_valid rises 3 cycles after start; move_fila=2, move_col=3, move_fallback=0; busy=0 the cycle after acceptance.
- occupied bit 13 set, rand sequence (2,3),(2,3),(0,1): accepted move is (0,1) with 3 tries. With CPU_MOVE_STATS_EN, last_tries=3.
- rand_fila=7 (out of range) for all samples, only cell 24 free, MAX_TRIES=8: SCAN reaches index 24; move (4,4), move_fallback=1. With CPU_MOVE_STATS_EN, fallback_count=1.
- occupied all ones, start: board_full is high for exactly one cycle after scanning index 24; move_valid is never asserted; state returns to IDLE.
- move_ready=0 for 10 cycles in OFFER while rand inputs toggle: outputs stay stable and move_valid stays high; a second start is ignored; accepted on ready=1.
- reset asserted mid-SCAN: outputs go to 0 immediately (asynchronous). After release, start with empty board gives a normal 3-cycle move.
